// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
// Holds the fetch FSM state encoding and the default instruction width.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fetch_state_t;

  localparam int INSTR_W = 9;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives prog_ctr into the ROM, registers mach_code into
// instr/instr_pc/instr_valid. Ports: clk, rst_n, start, stall, branch_en,
// branch_tgt, mach_code, program_done -> prog_ctr, instr, instr_pc,
// instr_valid, busy, done.
module instr_fetch_unit #(
  parameter int D       = 12,
  parameter int INSTR_W = fetch_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_en,
  input  logic [D-1:0]       branch_tgt,
  input  logic [INSTR_W-1:0] mach_code,
  input  logic               program_done,
  output logic [D-1:0]       prog_ctr,
  output logic [INSTR_W-1:0] instr,
  output logic [D-1:0]       instr_pc,
  output logic               instr_valid,
  output logic               busy,
  output logic               done
);
  import fetch_pkg::*;

  localparam logic [D-1:0] PC_MAX = '1;

  fetch_state_t state_q;
  fetch_state_t state_d;

  // Last address was fetched; retire to DONE on the next
  // unstalled edge so the final word is seen valid first.
  logic last_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (!stall && !branch_en) begin
          if (last_q || program_done)
            state_d = DONE;
        end
      end
      DONE: if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prog_ctr    <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            prog_ctr    <= '0;
            instr_valid <= 1'b0;
            last_q      <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (branch_en) begin
              // Word fetched this cycle is wrong-path.
              prog_ctr    <= branch_tgt;
              instr_valid <= 1'b0;
              last_q      <= 1'b0;
            end else if (last_q || program_done) begin
              instr_valid <= 1'b0;
              last_q      <= 1'b0;
            end else begin
              instr       <= mach_code;
              instr_pc    <= prog_ctr;
              instr_valid <= 1'b1;
              if (prog_ctr == PC_MAX)
                last_q <= 1'b1;
              else
                prog_ctr <= prog_ctr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// Directed scenarios plus random stall/branch/start against a model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stall, branch_en;
  logic [11:0] branch_tgt;
  logic [8:0]  mach_code;
  logic        program_done;
  logic [11:0] prog_ctr, instr_pc;
  logic [8:0]  instr;
  logic        instr_valid, busy, done;

  logic        s_start;
  logic [3:0]  s_pc, s_ipc;
  logic [8:0]  s_code, s_instr;
  logic        s_valid, s_busy, s_done;

  logic [8:0] rom [4096];
  int end_addr;

  int n_checks = 0;
  int n_err = 0;

  int m_mode;
  int m_pc, m_ipc;
  logic [8:0] m_instr;
  bit m_valid, m_tail;

  always #5 clk = ~clk;

  assign mach_code    = rom[prog_ctr];
  assign program_done = (int'(prog_ctr) == end_addr);
  assign s_code       = 9'h100 + 9'(s_pc);

  instr_fetch_unit #(.D(12), .INSTR_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_en(branch_en), .branch_tgt(branch_tgt),
    .mach_code(mach_code), .program_done(program_done),
    .prog_ctr(prog_ctr), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .busy(busy), .done(done)
  );

  instr_fetch_unit #(.D(4), .INSTR_W(9)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .stall(1'b0),
    .branch_en(1'b0), .branch_tgt(4'd0),
    .mach_code(s_code), .program_done(1'b0),
    .prog_ctr(s_pc), .instr(s_instr), .instr_pc(s_ipc),
    .instr_valid(s_valid), .busy(s_busy), .done(s_done)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_mode = 0; m_pc = 0; m_ipc = 0;
    m_instr = '0; m_valid = 0; m_tail = 0;
  endfunction

  // Fetch rules: one word per unstalled cycle, branch flushes,
  // end-of-program or top address retires the run.
  function automatic void m_step();
    if (m_mode != 1) begin
      if (start) begin
        m_mode = 1; m_pc = 0; m_valid = 0; m_tail = 0;
      end
      return;
    end
    if (stall) return;
    if (branch_en) begin
      m_pc = int'(branch_tgt); m_valid = 0; m_tail = 0;
    end else if (m_tail || m_pc == end_addr) begin
      m_mode = 2; m_valid = 0; m_tail = 0;
    end else begin
      m_instr = rom[m_pc]; m_ipc = m_pc; m_valid = 1;
      if (m_pc == 4095) m_tail = 1;
      else m_pc = m_pc + 1;
    end
  endfunction

  task automatic check_model();
    chk("prog_ctr", 32'(prog_ctr), 32'(m_pc));
    chk("instr", 32'(instr), 32'(m_instr));
    chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_mode == 1));
    chk("done", 32'(done), 32'(m_mode == 2));
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
    check_model();
    start = 0; stall = 0; branch_en = 0; s_start = 0;
  endtask

  initial begin
    rst_n = 0; start = 0; stall = 0; branch_en = 0;
    branch_tgt = '0; s_start = 0; end_addr = 3;
    m_reset();
    for (int i = 0; i < 4096; i++) rom[i] = 9'bx;
    rom[0] = 9'h07E; rom[1] = 9'h066; rom[2] = 9'h07A;
    #12;
    chk("rst_pc", 32'(prog_ctr), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_busy", 32'({busy, done}), 0);
    @(negedge clk); rst_n = 1;
    tick();

    // Short program then end-of-program flag.
    start = 1; tick();
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_w0", 32'({instr_valid, instr_pc, instr}), {1'b1, 12'd0, 9'h07E});
    tick();
    chk("t1_w1", 32'({instr_valid, instr_pc, instr}), {1'b1, 12'd1, 9'h066});
    tick();
    chk("t1_w2", 32'({instr_valid, instr_pc, instr}), {1'b1, 12'd2, 9'h07A});
    tick();
    chk("t1_done", 32'({done, instr_valid, busy}), 32'b100);

    // Stall freezes everything.
    for (int i = 0; i < 4096; i++) rom[i] = 9'($urandom);
    end_addr = 5000;
    start = 1; tick();
    repeat (5) tick();
    chk("t2_pc5", 32'(prog_ctr), 5);
    for (int i = 0; i < 3; i++) begin
      stall = 1; tick();
      chk("t2_frozen", 32'({instr_valid, prog_ctr, instr}),
          {1'b1, 12'd5, rom[4]});
    end
    tick();
    chk("t2_resume", 32'({instr_valid, instr_pc}), {1'b1, 12'd5});

    // Taken branch costs one bubble.
    branch_en = 1; branch_tgt = 12'd0; tick();
    repeat (4) tick();
    chk("t3_ipc3", 32'(instr_pc), 3);
    branch_en = 1; branch_tgt = 12'h040; tick();
    chk("t3_bubble", 32'({instr_valid, prog_ctr}), {1'b0, 12'h040});
    tick();
    chk("t3_tgt", 32'({instr_valid, instr_pc, instr}),
        {1'b1, 12'h040, rom[12'h040]});

    // Branch wins over concurrent end-of-program.
    end_addr = 12'h041;
    branch_en = 1; branch_tgt = 12'h010; tick();
    chk("t4_run", 32'({busy, done, prog_ctr}), {1'b1, 1'b0, 12'h010});
    end_addr = 12'h014;
    repeat (5) tick();
    chk("t4_end", 32'({done, prog_ctr}), {1'b1, 12'h014});

    // Top-of-range stop on the 4-bit instance.
    s_start = 1; tick();
    repeat (16) tick();
    chk("t5_last", 32'({s_valid, s_ipc, s_instr, s_done}),
        {1'b1, 4'd15, 9'h10F, 1'b0});
    tick();
    chk("t5_done", 32'({s_done, s_valid, s_pc, s_busy}),
        {1'b1, 1'b0, 4'd15, 1'b0});

    // Random start/stall/branch traffic.
    end_addr = 30;
    for (int c = 0; c < 400; c++) begin
      start = ($urandom_range(0, 15) == 0);
      stall = ($urandom_range(0, 3) == 0);
      branch_en = ($urandom_range(0, 9) == 0);
      branch_tgt = 12'($urandom_range(0, 63));
      tick();
    end

    // Async reset mid-run, then refetch from 0.
    start = 1; tick();
    repeat (3) tick();
    #3 rst_n = 0;
    #1;
    m_reset();
    chk("t6_async", 32'({prog_ctr, instr, instr_pc}), 0);
    chk("t6_flags", 32'({instr_valid, busy, done}), 0);
    @(negedge clk); rst_n = 1;
    start = 1; tick();
    tick();
    chk("t6_refetch", 32'({instr_valid, instr_pc, instr}),
        {1'b1, 12'd0, rom[0]});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
